// File: rtl/accum_avg_32_pkg.sv
// Shared widths, step counts and FSM encoding for the frame-average reader.
// The rounding build is selected by defining ACCUM_AVG_ROUND_EN.
package accum_avg_32_pkg;

  localparam int ACC_W      = 32;
  localparam int CNT_W      = 16;
  localparam int DVD_W      = ACC_W + 1;
  localparam int DIV_STEPS  = 33;
  localparam int STEP_W     = 6;
  localparam int SETTLE_CYC = 2;

  localparam logic [ACC_W-1:0] DZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_LOAD   = 3'd2,
    ST_DIV    = 3'd3,
    ST_DONE   = 3'd4
  } fsm_state_t;

endpackage

// File: rtl/accum_avg_32_div.sv
// Sequential restoring divider: 33-bit dividend by 16-bit divisor,
// one quotient bit per cycle, MSB first.
module restoring_div_33x16
  import accum_avg_32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             abort,
  input  logic [DVD_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [DVD_W-1:0] quot,
  output logic             done
);

  logic [DVD_W-1:0]  qd;
  logic [DVD_W-1:0]  qd_next;
  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  rem_next;
  logic [CNT_W-1:0]  dvs;
  logic [STEP_W-1:0] step;
  logic              running;
  logic [CNT_W:0]    shifted;
  logic [CNT_W:0]    diff;
  logic              ge;

  // qd starts as the dividend and fills with quotient bits from the LSB
  // while dividend bits leave from the MSB into the partial remainder.
  always_comb begin
    shifted  = {rem, qd[DVD_W-1]};
    diff     = shifted - {1'b0, dvs};
    ge       = (shifted >= {1'b0, dvs});
    rem_next = ge ? diff[CNT_W-1:0] : shifted[CNT_W-1:0];
    qd_next  = {qd[DVD_W-2:0], ge};
  end

  // The final quotient is presented in the same cycle as done so the
  // caller can capture it on the step that completes the division.
  assign quot = qd_next;
  assign done = running && (step == STEP_W'(DIV_STEPS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      qd      <= '0;
      rem     <= '0;
      dvs     <= '0;
      step    <= '0;
      running <= 1'b0;
    end else if (abort) begin
      step    <= '0;
      running <= 1'b0;
    end else if (load) begin
      qd      <= dividend;
      rem     <= '0;
      dvs     <= divisor;
      step    <= '0;
      running <= 1'b1;
    end else if (running) begin
      qd  <= qd_next;
      rem <= rem_next;
      if (done) begin
        running <= 1'b0;
      end else begin
        step <= step + 1'b1;
      end
    end
  end

endmodule

// File: rtl/accum_avg_32.sv
// Frame-average reader: counts sample strobes per frame and divides the settled
// accumulator result by that count. ACCUM_AVG_ROUND_EN selects half-up rounding.
module accum_avg_32
  import accum_avg_32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [4:0]       state,
  input  logic [ACC_W-1:0] Acc_In,
  input  logic             start,
  output logic [ACC_W-1:0] Avg,
  output logic [CNT_W-1:0] Cnt,
  output logic             busy,
  output logic             valid,
  output logic             dz_err
);

  fsm_state_t       fsm;
  fsm_state_t       fsm_next;
  logic             state_0;
  logic [1:0]       settle_cnt;
  logic             dz_pend;
  logic             div_load;
  logic             div_abort;
  logic             div_done;
  logic [DVD_W-1:0] dividend;
  logic [DVD_W-1:0] quot;

  // Registered to line up with the accumulator's one-cycle-delayed clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_0 <= 1'b0;
    end else begin
      state_0 <= (state == 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state_0) begin
      Cnt <= '0;
    end else if (en && (Cnt != '1)) begin
      Cnt <= Cnt + 1'b1;
    end
  end

`ifdef ACCUM_AVG_ROUND_EN
  assign dividend = {1'b0, Acc_In} + {{(DVD_W-CNT_W){1'b0}}, Cnt >> 1};
`else
  assign dividend = {1'b0, Acc_In};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= ST_IDLE;
    end else begin
      fsm <= fsm_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (fsm != ST_SETTLE)) begin
      settle_cnt <= '0;
    end else begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  always_comb begin
    fsm_next  = fsm;
    div_load  = 1'b0;
    div_abort = 1'b0;
    case (fsm)
      ST_IDLE: begin
        if (start) fsm_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (state_0) begin
          fsm_next  = ST_IDLE;
          div_abort = 1'b1;
        end else if (settle_cnt == 2'(SETTLE_CYC - 1)) begin
          fsm_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (state_0) begin
          fsm_next  = ST_IDLE;
          div_abort = 1'b1;
        end else begin
          fsm_next = ST_DIV;
          div_load = 1'b1;
        end
      end
      ST_DIV: begin
        if (state_0) begin
          fsm_next  = ST_IDLE;
          div_abort = 1'b1;
        end else if (div_done) begin
          fsm_next = ST_DONE;
        end
      end
      ST_DONE: begin
        fsm_next = ST_IDLE;
      end
      default: begin
        fsm_next = ST_IDLE;
      end
    endcase
  end

  assign busy  = (fsm != ST_IDLE);
  assign valid = (fsm == ST_DONE);

  // Quotient bit 32 can only be set by a zero divisor, already flagged by dz_pend.
  always_ff @(posedge clk) begin
    if (rst) begin
      Avg     <= '0;
      dz_err  <= 1'b0;
      dz_pend <= 1'b0;
    end else begin
      if (div_load) begin
        dz_pend <= (Cnt == '0);
      end
      if ((fsm == ST_DIV) && (fsm_next == ST_DONE)) begin
        Avg    <= (dz_pend || quot[DVD_W-1]) ? DZ_QUOT : quot[ACC_W-1:0];
        dz_err <= dz_pend;
      end else if ((fsm == ST_IDLE) && start) begin
        dz_err <= 1'b0;
      end
    end
  end

  restoring_div_33x16 u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .abort    (div_abort),
    .dividend (dividend),
    .divisor  (Cnt),
    .quot     (quot),
    .done     (div_done)
  );

endmodule

// File: tb/tb_accum_avg_32.sv
// Randomized bench for accum_avg_32 against an arithmetic model of the frame mean.
module tb_accum_avg_32;

  logic        clk;
  logic        rst;
  logic        en;
  logic [4:0]  state;
  logic [31:0] acc_in;
  logic        start;
  logic [31:0] avg;
  logic [15:0] cnt;
  logic        busy;
  logic        valid;
  logic        dz_err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_avg;

  accum_avg_32 dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .state  (state),
    .Acc_In (acc_in),
    .start  (start),
    .Avg    (avg),
    .Cnt    (cnt),
    .busy   (busy),
    .valid  (valid),
    .dz_err (dz_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: frame mean from plain arithmetic
  function automatic logic [31:0] model_avg(input logic [31:0] acc, input int n);
    longint unsigned a;
    if (n == 0) return 32'hFFFF_FFFF;
    a = longint'(acc);
`ifdef ACCUM_AVG_ROUND_EN
    a = a + longint'(n / 2);
`endif
    return 32'(a / longint'(n));
  endfunction

  // drivers
  task automatic frame_clear();
    state = 5'd0;
    tick();
    state = 5'($urandom_range(1, 31));
    tick();
    tick();
  endtask

  task automatic send_en(input int n);
    for (int i = 0; i < n; i++) begin
      en = 1'b1;
      tick();
      en = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end
    tick();
  endtask

  task automatic start_and_check(input string tag, input logic [31:0] acc, input int n,
                                 input bit en_in_div);
    int lat;
    int extra;
    logic [31:0] exp_avg;
    check_eq({tag, "_cnt"}, 64'(cnt), 64'(n > 65535 ? 65535 : n));
    acc_in = acc;
    exp_q.push_back(model_avg(acc, n));
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    extra = 0;
    check_eq({tag, "_busy1"}, 64'(busy), 64'd1);
    check_eq({tag, "_dzclr"}, 64'(dz_err), 64'd0);
    while (!valid && lat < 60) begin
      en = (en_in_div && lat >= 4 && lat < 30) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (en) extra++;
      tick();
      lat++;
    end
    en = 1'b0;
    check_eq({tag, "_lat"}, 64'(lat), 64'd37);
    exp_avg = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
    check_eq({tag, "_avg"}, 64'(avg), 64'(exp_avg));
    check_eq({tag, "_dz"}, 64'(dz_err), 64'(n == 0));
    check_eq({tag, "_cntdiv"}, 64'(cnt), 64'(n + extra));
    last_avg = exp_avg;
    tick();
    check_eq({tag, "_busy38"}, 64'(busy), 64'd0);
    check_eq({tag, "_valid38"}, 64'(valid), 64'd0);
  endtask

  task automatic run_avg(input string tag, input logic [31:0] acc, input int n,
                         input bit en_in_div);
    frame_clear();
    check_eq({tag, "_clr"}, 64'(cnt), 64'd0);
    send_en(n);
    start_and_check(tag, acc, n, en_in_div);
  endtask

  initial begin
    int vcount;
    int vcyc;
    logic [31:0] acc;
    rst    = 1'b1;
    en     = 1'b0;
    state  = 5'd1;
    acc_in = '0;
    start  = 1'b0;
    last_avg = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_eq("rst_avg", 64'(avg), 64'd0);
    check_eq("rst_cnt", 64'(cnt), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_valid", 64'(valid), 64'd0);
    check_eq("rst_dz", 64'(dz_err), 64'd0);

    run_avg("basic", 32'd102, 4, 1'b0);
    run_avg("dz", $urandom, 0, 1'b0);
    run_avg("after_dz", $urandom, 7, 1'b1);
    run_avg("max_n1", 32'hFFFF_FFFF, 1, 1'b0);
    run_avg("max_n2", 32'hFFFF_FFFF, 2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_avg($sformatf("rnd%0d", i), $urandom, $urandom_range(1, 300), 1'($urandom_range(0, 1)));
    end

    // second start while busy is ignored
    frame_clear();
    send_en(3);
    acc = $urandom;
    acc_in = acc;
    start = 1'b1;
    vcount = 0;
    vcyc   = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = (c == 10);
      if (valid) begin
        vcount++;
        vcyc = c;
      end
      if (c == 38) check_eq("dbl_busy38", 64'(busy), 64'd0);
    end
    start = 1'b0;
    check_eq("dbl_vcount", 64'(vcount), 64'd1);
    check_eq("dbl_vcyc", 64'(vcyc), 64'd37);
    check_eq("dbl_avg", 64'(avg), 64'(model_avg(acc, 3)));
    last_avg = model_avg(acc, 3);

    // frame clear mid-division aborts
    frame_clear();
    send_en(5);
    acc_in = $urandom;
    start = 1'b1;
    vcount = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = 1'b0;
      if (valid) vcount++;
      if (c == 20) state = 5'd0;
      if (c == 23) check_eq("abort_busy", 64'(busy), 64'd0);
    end
    check_eq("abort_valid", 64'(vcount), 64'd0);
    check_eq("abort_avg", 64'(avg), 64'(last_avg));
    check_eq("abort_cnt", 64'(cnt), 64'd0);
    state = 5'd3;
    tick();

    // counter saturation, then a division by the saturated count
    frame_clear();
    en = 1'b1;
    repeat (70000) tick();
    en = 1'b0;
    tick();
    check_eq("sat_cnt", 64'(cnt), 64'hFFFF);
    start_and_check("sat", $urandom, 65535, 1'b0);

    // reset mid-division after a divide-by-zero left outputs nonzero
    run_avg("dz2", $urandom, 0, 1'b0);
    frame_clear();
    send_en(3);
    acc_in = $urandom;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rstdiv_avg", 64'(avg), 64'd0);
    check_eq("rstdiv_cnt", 64'(cnt), 64'd0);
    check_eq("rstdiv_busy", 64'(busy), 64'd0);
    check_eq("rstdiv_valid", 64'(valid), 64'd0);
    check_eq("rstdiv_dz", 64'(dz_err), 64'd0);
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (valid) vcount++;
    end
    check_eq("rstdiv_novalid", 64'(vcount), 64'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
